// File: rtl/axi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axi_pkg
// Purpose  : AXI3 encodings and the instruction read bridge state type.
// Revision : 1.0
// ============================================================================
package axi_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    localparam logic [2:0] AXI_SIZE_1B = 3'b000;
    localparam logic [2:0] AXI_SIZE_2B = 3'b001;
    localparam logic [2:0] AXI_SIZE_4B = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AR   = 2'd1,
        ST_R    = 2'd2,
        ST_WACK = 2'd3
    } ibr_state_t;

    // SRAM-like size 3 has no wider AXI meaning on a 32-bit bus, so it reads a word
    function automatic logic [2:0] sram_to_axi_size(input logic [1:0] i_size);
        logic [2:0] w_sz;
        case (i_size)
            2'd0:    w_sz = AXI_SIZE_1B;
            2'd1:    w_sz = AXI_SIZE_2B;
            default: w_sz = AXI_SIZE_4B;
        endcase
        return w_sz;
    endfunction

endpackage
`default_nettype wire

// File: rtl/inst_axi_rd_bridge_if.sv
`default_nettype none
// ============================================================================
// Module   : inst_axi_rd_bridge_if
// Purpose  : SRAM-like miss port plus AXI3 AR/R channels of the I-side bridge.
// Revision : 1.0
// ============================================================================
interface inst_axi_rd_bridge_if #(
    parameter int ADDR_W = 32
) ();

    logic              req;
    logic              wr;
    logic [1:0]        size;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic              addr_ok;
    logic              data_ok;
    logic              bus_err;

    logic [3:0]        arid;
    logic [ADDR_W-1:0] araddr;
    logic [3:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic [1:0]        arlock;
    logic [3:0]        arcache;
    logic [2:0]        arprot;
    logic              arvalid;
    logic              arready;

    logic [3:0]        rid;
    logic [31:0]       rdata_axi;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    // The bridge itself: SRAM-like slave toward the cache, AXI master toward the bus
    modport master (
        input  req, wr, size, addr, wdata,
        output rdata, addr_ok, data_ok, bus_err,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata_axi, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        output req, wr, size, addr, wdata,
        input  rdata, addr_ok, data_ok, bus_err,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata_axi, rresp, rlast, rvalid,
        input  rready
    );

endinterface
`default_nettype wire

// File: rtl/kseg_addr_map.sv
`default_nettype none
// ============================================================================
// Module   : kseg_addr_map
// Purpose  : MIPS kseg0/kseg1 virtual-to-physical fold (clears bits [31:29]).
// Revision : 1.0
// ============================================================================
module kseg_addr_map #(
    parameter int ADDR_W = 32
) (
    input  wire logic [ADDR_W-1:0] i_vaddr,
    output logic      [ADDR_W-1:0] o_paddr
);

    // 0x8000_0000..0xBFFF_FFFF is exactly the region with top bits 2'b10
    always_comb begin
        o_paddr = i_vaddr;
        if (i_vaddr[31:30] == 2'b10) begin
            o_paddr[31:29] = 3'b000;
        end
    end

endmodule
`default_nettype wire

// File: rtl/inst_axi_rd_bridge.sv
`default_nettype none
// ============================================================================
// Module   : inst_axi_rd_bridge
// Purpose  : One-outstanding, single-beat AXI3 read bridge for I-cache misses.
//            Define IBRIDGE_KSEG_MAP_EN to fold kseg0/kseg1 addresses.
// Revision : 1.0
// ============================================================================
module inst_axi_rd_bridge
    import axi_pkg::*;
#(
    parameter logic [3:0] ARID_VAL = 4'd0,
    parameter int         ADDR_W   = 32
) (
    input  wire logic             clk,
    input  wire logic             rst,
    inst_axi_rd_bridge_if.master  bus
);

    ibr_state_t        r_state;
    logic              r_arvalid;
    logic              r_rready;
    logic [ADDR_W-1:0] r_araddr;
    logic [2:0]        r_arsize;

    logic [ADDR_W-1:0] w_paddr;
    logic              w_ar_hs;
    logic              w_r_done;
    logic              w_wack;
    logic              w_unused_ok;

`ifdef IBRIDGE_KSEG_MAP_EN
    kseg_addr_map #(
        .ADDR_W (ADDR_W)
    ) u_kseg_addr_map (
        .i_vaddr (bus.addr),
        .o_paddr (w_paddr)
    );
`else
    assign w_paddr = bus.addr;
`endif

    assign w_ar_hs  = r_arvalid & bus.arready;
    assign w_r_done = r_rready & bus.rvalid & bus.rlast;
    assign w_wack   = (r_state == ST_WACK);

    // rid needs no matching with a single transaction in flight
    assign w_unused_ok = ^{bus.wdata, bus.rid};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b0;
            r_araddr  <= '0;
            r_arsize  <= AXI_SIZE_4B;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.req) begin
                        if (bus.wr) begin
                            r_state <= ST_WACK;
                        end else begin
                            r_araddr  <= w_paddr;
                            r_arsize  <= sram_to_axi_size(bus.size);
                            r_arvalid <= 1'b1;
                            r_state   <= ST_AR;
                        end
                    end
                end
                ST_AR: begin
                    if (w_ar_hs) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= ST_R;
                    end
                end
                ST_R: begin
                    // A beat without rlast is a slave protocol error and is dropped
                    if (w_r_done) begin
                        r_rready <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                end
                ST_WACK: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.addr_ok = w_ar_hs | w_wack;
    assign bus.data_ok = w_r_done | w_wack;
    assign bus.bus_err = (w_r_done & (bus.rresp != AXI_RESP_OKAY)) | w_wack;
    assign bus.rdata   = w_r_done ? bus.rdata_axi : 32'h0;

    assign bus.arid    = ARID_VAL;
    assign bus.araddr  = r_araddr;
    assign bus.arlen   = 4'd0;
    assign bus.arsize  = r_arsize;
    assign bus.arburst = AXI_BURST_INCR;
    assign bus.arlock  = 2'b00;
    assign bus.arcache = 4'd0;
    assign bus.arprot  = 3'd0;
    assign bus.arvalid = r_arvalid;
    assign bus.rready  = r_rready;

endmodule
`default_nettype wire

// File: tb/tb_inst_axi_rd_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_axi_rd_bridge
// Purpose  : Directed vector bench for inst_axi_rd_bridge.
// Revision : 1.0
// ============================================================================
module tb_inst_axi_rd_bridge;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    inst_axi_rd_bridge_if #(.ADDR_W(32)) bus ();

    inst_axi_rd_bridge #(
        .ARID_VAL (4'd5),
        .ADDR_W   (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] rdat;
        logic [1:0]  rresp;
        int          ar_delay;
        int          r_junk;
        logic [2:0]  exp_arsize;
        logic [31:0] exp_araddr;
        logic        exp_err;
    } vec_t;

    vec_t vecs [10];

`ifdef IBRIDGE_KSEG_MAP_EN
    localparam logic [31:0] c_EXP_BFC = 32'h1FC0_0000;
    localparam logic [31:0] c_EXP_900 = 32'h1000_0008;
`else
    localparam logic [31:0] c_EXP_BFC = 32'hBFC0_0000;
    localparam logic [31:0] c_EXP_900 = 32'h9000_0008;
`endif

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Starts at posedge+2 with the DUT idle; returns at posedge+3 with it idle again
    task automatic do_txn(input vec_t v, input int idx);
        string t;
        t = $sformatf("v%0d", idx);
        bus.req       = 1'b1;
        bus.wr        = v.wr;
        bus.size      = v.size;
        bus.addr      = v.addr;
        bus.arready   = (v.ar_delay == 0);
        bus.rvalid    = 1'b0;
        bus.rlast     = 1'b0;
        @(posedge clk); #2;
        if (v.wr) begin
            #1;
            chk({t, " wack addr_ok"}, {31'd0, bus.addr_ok}, 32'd1);
            chk({t, " wack data_ok"}, {31'd0, bus.data_ok}, 32'd1);
            chk({t, " wack bus_err"}, {31'd0, bus.bus_err}, 32'd1);
            chk({t, " wack rdata"}, bus.rdata, 32'd0);
            chk({t, " wack arvalid"}, {31'd0, bus.arvalid}, 32'd0);
            bus.req = 1'b0;
            @(posedge clk); #3;
            chk({t, " post addr_ok"}, {31'd0, bus.addr_ok}, 32'd0);
            chk({t, " post data_ok"}, {31'd0, bus.data_ok}, 32'd0);
            chk({t, " post arvalid"}, {31'd0, bus.arvalid}, 32'd0);
            return;
        end
        chk({t, " arvalid"}, {31'd0, bus.arvalid}, 32'd1);
        chk({t, " araddr"}, bus.araddr, v.exp_araddr);
        chk({t, " arsize"}, {29'd0, bus.arsize}, {29'd0, v.exp_arsize});
        chk({t, " arlen"}, {28'd0, bus.arlen}, 32'd0);
        chk({t, " arburst"}, {30'd0, bus.arburst}, 32'd1);
        chk({t, " arid"}, {28'd0, bus.arid}, 32'd5);
        chk({t, " arlock/cache/prot"}, {23'd0, bus.arlock, bus.arcache, bus.arprot}, 32'd0);
        chk({t, " rready in AR"}, {31'd0, bus.rready}, 32'd0);
        for (int i = 0; i < v.ar_delay; i++) begin
            #1;
            chk({t, " addr_ok while stalled"}, {31'd0, bus.addr_ok}, 32'd0);
            @(posedge clk); #2;
            chk({t, " arvalid held"}, {31'd0, bus.arvalid}, 32'd1);
            chk({t, " araddr stable"}, bus.araddr, v.exp_araddr);
        end
        bus.arready = 1'b1;
        #1;
        chk({t, " addr_ok"}, {31'd0, bus.addr_ok}, 32'd1);
        chk({t, " data_ok early"}, {31'd0, bus.data_ok}, 32'd0);
        @(posedge clk); #2;
        bus.arready = 1'b0;
        bus.req     = 1'b0;
        chk({t, " arvalid dropped"}, {31'd0, bus.arvalid}, 32'd0);
        chk({t, " rready"}, {31'd0, bus.rready}, 32'd1);
        for (int i = 0; i < v.r_junk; i++) begin
            bus.rvalid    = 1'b1;
            bus.rlast     = 1'b0;
            bus.rdata_axi = 32'hBAD0_BAD0;
            bus.rresp     = 2'b00;
            #1;
            chk({t, " data_ok on non-last beat"}, {31'd0, bus.data_ok}, 32'd0);
            @(posedge clk); #2;
            chk({t, " rready after non-last"}, {31'd0, bus.rready}, 32'd1);
        end
        bus.rvalid    = 1'b1;
        bus.rlast     = 1'b1;
        bus.rdata_axi = v.rdat;
        bus.rresp     = v.rresp;
        #1;
        chk({t, " data_ok"}, {31'd0, bus.data_ok}, 32'd1);
        chk({t, " rdata"}, bus.rdata, v.rdat);
        chk({t, " bus_err"}, {31'd0, bus.bus_err}, {31'd0, v.exp_err});
        chk({t, " addr_ok in R"}, {31'd0, bus.addr_ok}, 32'd0);
        @(posedge clk); #2;
        bus.rvalid = 1'b0;
        bus.rlast  = 1'b0;
        #1;
        chk({t, " data_ok clear"}, {31'd0, bus.data_ok}, 32'd0);
        chk({t, " rready clear"}, {31'd0, bus.rready}, 32'd0);
        chk({t, " bus_err clear"}, {31'd0, bus.bus_err}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        failures = 0;
        //        wr    size   addr            rdat           rresp  ard jnk  arsize   araddr         err
        vecs[0] = '{1'b0, 2'd2, 32'h0000_1000, 32'hDEAD_BEEF, 2'b00, 0, 0, 3'd2, 32'h0000_1000, 1'b0};
        vecs[1] = '{1'b0, 2'd0, 32'h0000_2003, 32'h1122_3344, 2'b00, 0, 0, 3'd0, 32'h0000_2003, 1'b0};
        vecs[2] = '{1'b0, 2'd1, 32'h0000_0102, 32'hCAFE_F00D, 2'b00, 1, 0, 3'd1, 32'h0000_0102, 1'b0};
        vecs[3] = '{1'b0, 2'd3, 32'h0000_4000, 32'h0BAD_CAFE, 2'b10, 0, 0, 3'd2, 32'h0000_4000, 1'b1};
        vecs[4] = '{1'b0, 2'd2, 32'h0000_4004, 32'h5555_AAAA, 2'b00, 0, 0, 3'd2, 32'h0000_4004, 1'b0};
        vecs[5] = '{1'b0, 2'd2, 32'hBFC0_0000, 32'h3C1C_BFC0, 2'b00, 0, 0, 3'd2, c_EXP_BFC,     1'b0};
        vecs[6] = '{1'b0, 2'd2, 32'h9000_0008, 32'h0000_0001, 2'b00, 0, 0, 3'd2, c_EXP_900,     1'b0};
        vecs[7] = '{1'b0, 2'd2, 32'hC000_0004, 32'h8765_4321, 2'b00, 0, 2, 3'd2, 32'hC000_0004, 1'b0};
        vecs[8] = '{1'b1, 2'd2, 32'h0000_8000, 32'h0000_0000, 2'b00, 0, 0, 3'd2, 32'h0000_0000, 1'b1};
        vecs[9] = '{1'b0, 2'd2, 32'h0000_9000, 32'hA5A5_5A5A, 2'b11, 5, 0, 3'd2, 32'h0000_9000, 1'b1};

        rst           = 1'b1;
        bus.req       = 1'b0;
        bus.wr        = 1'b0;
        bus.size      = 2'd0;
        bus.addr      = 32'd0;
        bus.wdata     = 32'd0;
        bus.arready   = 1'b0;
        bus.rid       = 4'd0;
        bus.rdata_axi = 32'd0;
        bus.rresp     = 2'b00;
        bus.rlast     = 1'b0;
        bus.rvalid    = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("reset arvalid", {31'd0, bus.arvalid}, 32'd0);
        chk("reset rready", {31'd0, bus.rready}, 32'd0);
        chk("reset addr_ok", {31'd0, bus.addr_ok}, 32'd0);
        chk("reset data_ok", {31'd0, bus.data_ok}, 32'd0);
        chk("reset bus_err", {31'd0, bus.bus_err}, 32'd0);
        chk("reset araddr", bus.araddr, 32'd0);
        chk("reset arsize", {29'd0, bus.arsize}, 32'd2);
        chk("reset rdata", bus.rdata, 32'd0);
        rst = 1'b0;
        @(posedge clk); #2;

        for (int k = 0; k < 10; k++) begin
            do_txn(vecs[k], k);
        end

        // Reset while waiting in R, then a fresh read must still complete
        bus.req     = 1'b1;
        bus.wr      = 1'b0;
        bus.size    = 2'd2;
        bus.addr    = 32'h0000_3000;
        bus.arready = 1'b1;
        @(posedge clk); #2;
        @(posedge clk); #2;
        bus.req     = 1'b0;
        bus.arready = 1'b0;
        chk("rst-in-R rready before", {31'd0, bus.rready}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        chk("rst-in-R rready", {31'd0, bus.rready}, 32'd0);
        chk("rst-in-R arvalid", {31'd0, bus.arvalid}, 32'd0);
        chk("rst-in-R araddr", bus.araddr, 32'd0);
        chk("rst-in-R arsize", {29'd0, bus.arsize}, 32'd2);
        chk("rst-in-R data_ok", {31'd0, bus.data_ok}, 32'd0);
        @(posedge clk); #2;
        do_txn(vecs[0], 100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
